// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb_if
// Description : Bus bundle for the scoreboarded register file. It carries the
//               two read ports, the write port, the scoreboard set port, the
//               bulk-clear handshake and the debug tap.
//               master : the decode/writeback side that drives the requests
//               slave  : the register file itself
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_sb_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic [ADDR_W-1:0] r_read1;
    logic [ADDR_W-1:0] r_read2;
    logic [DATA_W-1:0] r_read1_data;
    logic [DATA_W-1:0] r_read2_data;
    logic              busy1;
    logic              busy2;
    logic              write;
    logic [ADDR_W-1:0] r_write;
    logic [DATA_W-1:0] r_write_data;
    logic              sb_set;
    logic [ADDR_W-1:0] sb_addr;
    logic              clear;
    logic              clear_busy;
    logic [ADDR_W-1:0] dbg_sel;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output r_read1, r_read2, write, r_write, r_write_data,
               sb_set, sb_addr, clear, dbg_sel,
        input  r_read1_data, r_read2_data, busy1, busy2, clear_busy, dbg_data
    );

    modport slave (
        input  r_read1, r_read2, write, r_write, r_write_data,
               sb_set, sb_addr, clear, dbg_sel,
        output r_read1_data, r_read2_data, busy1, busy2, clear_busy, dbg_data
    );
endinterface
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : 2**ADDR_W x DATA_W register file with two combinational read
//               ports, one synchronous write port, a per-register scoreboard
//               of pending writes, a sequential bulk-clear engine and an
//               optional hardwired-zero register 0.
// Ports       : clk   - clock, all state changes on the rising edge
//               rst_n - asynchronous active-low reset
//               bus   - regfile_sb_if.slave (read/write/scoreboard/clear/debug)
// Options     : define REGFILE_BYPASS_EN to forward same-cycle write data
//               (and the write's scoreboard clear) onto the read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 2,
    parameter int ZERO_REG0 = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_sb_if.slave  bus
);

    localparam int                c_DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(c_DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] w_clr_cnt_next;
    logic              w_clear_busy;

    logic [DATA_W-1:0] r_regs [c_DEPTH];
    logic [c_DEPTH-1:0] r_sb;

    logic w_zero_wr;      // write aimed at a hardwired-zero register 0
    logic w_zero_set;     // scoreboard set aimed at a hardwired-zero register 0
    logic w_wr_en;
    logic w_sb_set_en;

    // ------------------------------------------------------------------------
    // Register-0 masking
    // ------------------------------------------------------------------------
    if (ZERO_REG0 != 0) begin : g_zero_reg0
        assign w_zero_wr  = (bus.r_write == '0);
        assign w_zero_set = (bus.sb_addr == '0);
    end else begin : g_plain_reg0
        assign w_zero_wr  = 1'b0;
        assign w_zero_set = 1'b0;
    end

    assign w_wr_en     = bus.write && !w_clear_busy && !w_zero_wr;
    assign w_sb_set_en = bus.sb_set && !w_zero_set;

    // ------------------------------------------------------------------------
    // Clear engine: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
        end
    end

    // ------------------------------------------------------------------------
    // Clear engine: next state / outputs. clear_busy is decoded from the
    // CLEAR state, so it rises the cycle after the request and stays high
    // for exactly one cycle per register.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        w_clear_busy   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.clear) begin
                    w_state_next   = ST_CLEAR;
                    w_clr_cnt_next = '0;
                end
            end
            ST_CLEAR: begin
                // A further clear request here is ignored: no restart.
                w_clear_busy = 1'b1;
                if (r_clr_cnt == c_LAST) begin
                    w_state_next   = ST_IDLE;
                    w_clr_cnt_next = '0;
                end else begin
                    w_clr_cnt_next = r_clr_cnt + ADDR_W'(1);
                end
            end
            default: begin
                w_state_next   = ST_IDLE;
                w_clr_cnt_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Register array and scoreboard. The clear engine overrides everything on
    // the register it is sweeping; otherwise the scoreboard set is assigned
    // after the write's clear so that set wins on a same-address collision.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_sb <= '0;
        end else begin
            for (int i = 0; i < c_DEPTH; i++) begin
                if (w_clear_busy && (r_clr_cnt == ADDR_W'(i))) begin
                    r_regs[i] <= '0;
                    r_sb[i]   <= 1'b0;
                end else begin
                    if (w_wr_en && (bus.r_write == ADDR_W'(i))) begin
                        r_regs[i] <= bus.r_write_data;
                        r_sb[i]   <= 1'b0;
                    end
                    if (w_sb_set_en && (bus.sb_addr == ADDR_W'(i))) begin
                        r_sb[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Combinational read side
    // ------------------------------------------------------------------------
    assign bus.clear_busy = w_clear_busy;
    assign bus.dbg_data   = r_regs[bus.dbg_sel];

    always_comb begin
        bus.r_read1_data = r_regs[bus.r_read1];
        bus.r_read2_data = r_regs[bus.r_read2];
        bus.busy1        = r_sb[bus.r_read1];
        bus.busy2        = r_sb[bus.r_read2];
`ifdef REGFILE_BYPASS_EN
        // Forward the accepted write; its scoreboard bit would be cleared at
        // the edge unless a same-address set is also pending.
        if (w_wr_en && (bus.r_read1 == bus.r_write)) begin
            bus.r_read1_data = bus.r_write_data;
            bus.busy1        = w_sb_set_en && (bus.sb_addr == bus.r_read1);
        end
        if (w_wr_en && (bus.r_read2 == bus.r_write)) begin
            bus.r_read2_data = bus.r_write_data;
            bus.busy2        = w_sb_set_en && (bus.sb_addr == bus.r_read2);
        end
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb
// Description : Scoreboard bench for regfile_sb. Two instances run on the same
//               stimulus: dut0 with ZERO_REG0=0 and dut1 with ZERO_REG0=1.
//               Each cycle the stimulus side pushes the expected outputs of
//               both instances (from an array-level reference model) and a
//               monitor on the falling edge pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    localparam int c_DW    = 8;
    localparam int c_AW    = 2;
    localparam int c_DEPTH = 4;

    typedef struct {
        logic [7:0] d1;
        logic [7:0] d2;
        logic [7:0] dbg;
        logic       b1;
        logic       b2;
        logic       cb;
    } obs_t;

    typedef struct {
        obs_t o [2];
        int   cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [1:0] r_read1, r_read2, r_write, sb_addr, dbg_sel;
    logic [7:0] r_write_data;
    logic write, sb_set, clear;

    regfile_sb_if #(.DATA_W(c_DW), .ADDR_W(c_AW)) bus0 ();
    regfile_sb_if #(.DATA_W(c_DW), .ADDR_W(c_AW)) bus1 ();

    assign bus0.r_read1 = r_read1;      assign bus1.r_read1 = r_read1;
    assign bus0.r_read2 = r_read2;      assign bus1.r_read2 = r_read2;
    assign bus0.write   = write;        assign bus1.write   = write;
    assign bus0.r_write = r_write;      assign bus1.r_write = r_write;
    assign bus0.r_write_data = r_write_data;
    assign bus1.r_write_data = r_write_data;
    assign bus0.sb_set  = sb_set;       assign bus1.sb_set  = sb_set;
    assign bus0.sb_addr = sb_addr;      assign bus1.sb_addr = sb_addr;
    assign bus0.clear   = clear;        assign bus1.clear   = clear;
    assign bus0.dbg_sel = dbg_sel;      assign bus1.dbg_sel = dbg_sel;

    regfile_sb #(.DATA_W(c_DW), .ADDR_W(c_AW), .ZERO_REG0(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    regfile_sb #(.DATA_W(c_DW), .ADDR_W(c_AW), .ZERO_REG0(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model: plain arrays plus a count of clear cycles remaining.
    // ------------------------------------------------------------------------
    logic [7:0] m_mem  [2][c_DEPTH];
    logic       m_sb   [2][c_DEPTH];
    int         m_left [2];

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;
    int   cycle_no = 0;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < c_DEPTH; a++) begin
                m_mem[k][a] = 8'h00;
                m_sb[k][a]  = 1'b0;
            end
            m_left[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input logic wr, input logic [1:0] wa,
                              input logic [7:0] wd, input logic ss,
                              input logic [1:0] sa, input logic cl);
        bit z;
        bit busy;
        int idx;
        z    = (k == 1);
        busy = (m_left[k] > 0);
        if (wr && !busy && !(z && wa == 2'd0)) begin
            m_mem[k][wa] = wd;
            m_sb[k][wa]  = 1'b0;
        end
        if (ss && !(z && sa == 2'd0))
            m_sb[k][sa] = 1'b1;
        if (busy) begin
            idx = c_DEPTH - m_left[k];
            m_mem[k][idx] = 8'h00;
            m_sb[k][idx]  = 1'b0;
            m_left[k]     = m_left[k] - 1;
        end else if (cl) begin
            m_left[k] = c_DEPTH;
        end
    endtask

    function automatic obs_t model_obs(input int k, input logic wr,
                                       input logic [1:0] wa, input logic [7:0] wd,
                                       input logic ss, input logic [1:0] sa,
                                       input logic [1:0] r1, input logic [1:0] r2,
                                       input logic [1:0] ds);
        obs_t o;
        bit   z;
        bit   acc;
        z     = (k == 1);
        acc   = wr && (m_left[k] == 0) && !(z && wa == 2'd0);
        o.d1  = m_mem[k][r1];
        o.d2  = m_mem[k][r2];
        o.b1  = m_sb[k][r1];
        o.b2  = m_sb[k][r2];
        o.dbg = m_mem[k][ds];
        o.cb  = (m_left[k] > 0);
`ifdef REGFILE_BYPASS_EN
        if (acc && r1 == wa) begin
            o.d1 = wd;
            o.b1 = ss && (sa == r1) && !(z && sa == 2'd0);
        end
        if (acc && r2 == wa) begin
            o.d2 = wd;
            o.b2 = ss && (sa == r2) && !(z && sa == 2'd0);
        end
`else
        if (acc) o.cb = 1'b0;
`endif
        return o;
    endfunction

    // One clock cycle of stimulus, entered and left 1 time unit after a
    // rising edge.
    task automatic cyc(input logic rn, input logic wr, input logic [1:0] wa,
                       input logic [7:0] wd, input logic ss, input logic [1:0] sa,
                       input logic cl, input logic [1:0] r1, input logic [1:0] r2,
                       input logic [1:0] ds);
        exp_t e;
        rst_n        = rn;
        write        = wr;
        r_write      = wa;
        r_write_data = wd;
        sb_set       = ss;
        sb_addr      = sa;
        clear        = cl;
        r_read1      = r1;
        r_read2      = r2;
        dbg_sel      = ds;
        if (!rn) model_reset();
        for (int k = 0; k < 2; k++)
            e.o[k] = model_obs(k, wr, wa, wd, ss, sa, r1, r2, ds);
        e.cyc = cycle_no;
        exp_q.push_back(e);
        @(posedge clk);
        if (rn) begin
            for (int k = 0; k < 2; k++)
                model_step(k, wr, wa, wd, ss, sa, cl);
        end
        cycle_no++;
        #1;
    endtask

    task automatic idle(input logic [1:0] r1, input logic [1:0] r2, input logic [1:0] ds);
        cyc(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, r1, r2, ds);
    endtask

    task automatic wr_reg(input logic [1:0] wa, input logic [7:0] wd);
        cyc(1'b1, 1'b1, wa, wd, 1'b0, 2'd0, 1'b0, wa, wa, wa);
    endtask

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    task automatic chk(input string name, input int k, input int cy,
                       input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, k, cy, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        obs_t a [2];
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a[0].d1 = bus0.r_read1_data; a[1].d1 = bus1.r_read1_data;
            a[0].d2 = bus0.r_read2_data; a[1].d2 = bus1.r_read2_data;
            a[0].dbg = bus0.dbg_data;    a[1].dbg = bus1.dbg_data;
            a[0].b1 = bus0.busy1;        a[1].b1 = bus1.busy1;
            a[0].b2 = bus0.busy2;        a[1].b2 = bus1.busy2;
            a[0].cb = bus0.clear_busy;   a[1].cb = bus1.clear_busy;
            for (int k = 0; k < 2; k++) begin
                chk("read1_data", k, e.cyc, a[k].d1, e.o[k].d1);
                chk("read2_data", k, e.cyc, a[k].d2, e.o[k].d2);
                chk("dbg_data",   k, e.cyc, a[k].dbg, e.o[k].dbg);
                chk("busy1",      k, e.cyc, {7'd0, a[k].b1}, {7'd0, e.o[k].b1});
                chk("busy2",      k, e.cyc, {7'd0, a[k].b2}, {7'd0, e.o[k].b2});
                chk("clear_busy", k, e.cyc, {7'd0, a[k].cb}, {7'd0, e.o[k].cb});
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        logic rn, wr, ss, cl;
        rst_n = 1'b0; write = 1'b0; r_write = '0; r_write_data = '0;
        sb_set = 1'b0; sb_addr = '0; clear = 1'b0;
        r_read1 = '0; r_read2 = '0; dbg_sel = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset, then read every address.
        cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 2'd1, 2'd2);
        cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd3, 2'd2, 2'd1);
        for (int i = 0; i < 4; i++)
            idle(2'(i), 2'(3 - i), 2'(i));

        // Write 0xA5 to reg 2 with a same-cycle read, then read it back.
        cyc(1'b1, 1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 1'b0, 2'd2, 2'd0, 2'd2);
        idle(2'd2, 2'd2, 2'd2);

        // Scoreboard: set 3; write+set 3 together; write 3 alone.
        cyc(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b0, 2'd0, 2'd3, 2'd3);
        idle(2'd3, 2'd3, 2'd3);
        cyc(1'b1, 1'b1, 2'd3, 8'h5C, 1'b1, 2'd3, 1'b0, 2'd1, 2'd3, 2'd3);
        idle(2'd1, 2'd3, 2'd3);
        cyc(1'b1, 1'b1, 2'd3, 8'h6D, 1'b0, 2'd0, 1'b0, 2'd1, 2'd3, 2'd3);
        idle(2'd1, 2'd3, 2'd3);

        // Fill, clear, drop a mid-clear write, ignore a second clear pulse.
        for (int i = 0; i < 4; i++) wr_reg(2'(i), 8'(8'h11 * (i + 1)));
        cyc(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b1, 2'd0, 2'd1, 2'd0);
        cyc(1'b1, 1'b1, 2'd1, 8'hFF, 1'b0, 2'd0, 1'b0, 2'd1, 2'd2, 2'd1);
        cyc(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b1, 2'd1, 2'd3, 2'd2);
        cyc(1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b0, 2'd2, 2'd3, 2'd3);
        for (int i = 0; i < 6; i++) idle(2'(i), 2'(i + 1), 2'(i + 2));

        // Register 0 write and scoreboard set (dropped on dut1).
        cyc(1'b1, 1'b1, 2'd0, 8'h7E, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0);
        idle(2'd0, 2'd0, 2'd0);

        // Reset during the second clear cycle, then a clean clear.
        for (int i = 0; i < 4; i++) wr_reg(2'(i), 8'(8'h21 + 8'(i)));
        cyc(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1, 2'd1, 2'd2, 2'd3);
        idle(2'd1, 2'd2, 2'd3);
        cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd1, 2'd3, 2'd2);
        cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd2, 2'd3, 2'd3);
        for (int i = 0; i < 4; i++) wr_reg(2'(i), 8'(8'h31 + 8'(i)));
        cyc(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1, 2'd3, 2'd2, 2'd1);
        for (int i = 0; i < 6; i++) idle(2'(i), 2'(3 - i), 2'(i));

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            rn = ($urandom_range(0, 59) != 0);
            wr = rn && ($urandom_range(0, 1) == 1);
            ss = rn && ($urandom_range(0, 3) == 0);
            cl = rn && ($urandom_range(0, 11) == 0);
            cyc(rn, wr, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                ss, 2'($urandom_range(0, 3)), cl,
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)));
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
